// File: rtl/sram_bank_array_pkg.sv
// Shared constants, bank FSM state type and packed-bus slicing helper for the
// SRAM bank array.
package sram_bank_array_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic {
        BANK_IDLE     = 1'b0,
        BANK_CLEARING = 1'b1
    } bank_state_e;

    // Low bit of lane idx within a bus packed as NUM x width.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sram_bank_array_if.sv
// Memory-controller <-> SRAM bank array bus. The controller drives the
// requests (master); the bank array responds with data and status (slave).
interface sram_bank_array_if #(
    parameter int Addr_Width = 4,
    parameter int Nums_SRAM  = 3,
    parameter int Data_Width = 16
);
    logic [Nums_SRAM-1:0]            Mem_Clear;
    logic [Nums_SRAM-1:0]            En_Chip_Select;
    logic [Nums_SRAM-1:0]            En_Write;
    logic [Nums_SRAM-1:0]            En_Read;
    logic [Nums_SRAM*Addr_Width-1:0] Addr_Write;
    logic [Nums_SRAM*Addr_Width-1:0] Addr_Read;
    logic [Nums_SRAM*Data_Width-1:0] Data_In;
    logic [Nums_SRAM*Data_Width-1:0] Data_Out;
    logic [Nums_SRAM-1:0]            Data_Valid;
    logic [Nums_SRAM-1:0]            Clear_Busy;

    modport master (
        output Mem_Clear, En_Chip_Select, En_Write, En_Read,
        output Addr_Write, Addr_Read, Data_In,
        input  Data_Out, Data_Valid, Clear_Busy
    );

    modport slave (
        input  Mem_Clear, En_Chip_Select, En_Write, En_Read,
        input  Addr_Write, Addr_Read, Data_In,
        output Data_Out, Data_Valid, Clear_Busy
    );
endinterface

// File: rtl/sram_bank_array_bank.sv
// Single SRAM bank: storage array, IDLE/CLEARING FSM with zero-fill counter,
// registered read port. Optional macro SRAM_WRITE_FIRST_BYPASS_EN.
module sram_bank
    import sram_bank_array_pkg::*;
#(
    parameter int AW = ADDR_WIDTH_DEF,
    parameter int DW = DATA_WIDTH_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_cs,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_waddr,
    input  logic [AW-1:0] i_raddr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata,
    output logic          o_valid,
    output logic          o_busy
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];
    bank_state_e   r_state;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_rdata;
    logic          r_valid;
    logic          r_busy;

    logic          w_idle_acc;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic [DW-1:0] w_rd;

    // External access only in IDLE and only when no clear is being taken.
    assign w_idle_acc  = (r_state == BANK_IDLE) && !i_clear && i_cs;
    assign w_mem_we    = (r_state == BANK_CLEARING) || (w_idle_acc && i_we);
    assign w_mem_addr  = (r_state == BANK_CLEARING) ? r_cnt : i_waddr;
    assign w_mem_wdata = (r_state == BANK_CLEARING) ? '0 : i_wdata;

`ifdef SRAM_WRITE_FIRST_BYPASS_EN
    assign w_rd = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
`else
    assign w_rd = r_mem[i_raddr];
`endif

    // Contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= BANK_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                BANK_IDLE: begin
                    r_valid <= 1'b0;
                    if (i_clear) begin
                        r_state <= BANK_CLEARING;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else if (w_idle_acc && i_re) begin
                        r_rdata <= w_rd;
                        r_valid <= 1'b1;
                    end
                end
                BANK_CLEARING: begin
                    r_valid <= 1'b0;
                    if (r_cnt == {AW{1'b1}}) begin
                        r_state <= BANK_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= BANK_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_rdata = r_rdata;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;

endmodule

// File: rtl/sram_bank_array.sv
// SRAM bank array top: slices the packed controller bus into Nums_SRAM
// independent sram_bank instances. Optional macro SRAM_WRITE_FIRST_BYPASS_EN.
module sram_bank_array
    import sram_bank_array_pkg::*;
#(
    parameter int Addr_Width = ADDR_WIDTH_DEF,
    parameter int Ram_Depth  = 1 << Addr_Width,
    parameter int Nums_SRAM  = 3,
    parameter int Data_Width = DATA_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              Mem_reset_n,
    sram_bank_array_if.slave  bus
);
    logic [Nums_SRAM-1:0][Data_Width-1:0] w_rdata;
    logic [Nums_SRAM-1:0]                 w_valid;
    logic [Nums_SRAM-1:0]                 w_busy;

    for (genvar g = 0; g < Nums_SRAM; g++) begin : g_bank
        sram_bank #(
            .AW (Addr_Width),
            .DW (Data_Width)
        ) u_bank (
            .i_clk   (clk),
            .i_rst_n (Mem_reset_n),
            .i_clear (bus.Mem_Clear[g]),
            .i_cs    (bus.En_Chip_Select[g]),
            .i_we    (bus.En_Write[g]),
            .i_re    (bus.En_Read[g]),
            .i_waddr (bus.Addr_Write[slice_lo(g, Addr_Width) +: Addr_Width]),
            .i_raddr (bus.Addr_Read[slice_lo(g, Addr_Width) +: Addr_Width]),
            .i_wdata (bus.Data_In[slice_lo(g, Data_Width) +: Data_Width]),
            .o_rdata (w_rdata[g]),
            .o_valid (w_valid[g]),
            .o_busy  (w_busy[g])
        );
    end

    assign bus.Data_Out   = w_rdata;
    assign bus.Data_Valid = w_valid;
    assign bus.Clear_Busy = w_busy;

endmodule

// File: tb/tb_sram_bank_array.sv
// Self-checking bench for sram_bank_array: directed scenarios plus random
// traffic against a behavioural per-bank memory model.
module tb_sram_bank_array;
    localparam int AW = 4;
    localparam int NS = 3;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_bank_array_if #(.Addr_Width(AW), .Nums_SRAM(NS), .Data_Width(DW)) bus ();

    sram_bank_array #(.Addr_Width(AW), .Nums_SRAM(NS), .Data_Width(DW)) dut (
        .clk         (clk),
        .Mem_reset_n (rst_n),
        .bus         (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] m_mem [NS][DEPTH];
    int            m_left [NS];
    logic [DW-1:0] m_out  [NS];
    logic          m_vld  [NS];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_in();
        bus.Mem_Clear      = '0;
        bus.En_Chip_Select = '0;
        bus.En_Write       = '0;
        bus.En_Read        = '0;
        bus.Addr_Write     = '0;
        bus.Addr_Read      = '0;
        bus.Data_In        = '0;
    endtask

    task automatic set_wr(input int b, input int a, input logic [DW-1:0] d);
        bus.En_Chip_Select[b]   = 1'b1;
        bus.En_Write[b]         = 1'b1;
        bus.Addr_Write[b*AW+:AW] = AW'(a);
        bus.Data_In[b*DW+:DW]   = d;
    endtask

    task automatic set_rd(input int b, input int a);
        bus.En_Chip_Select[b]   = 1'b1;
        bus.En_Read[b]          = 1'b1;
        bus.Addr_Read[b*AW+:AW] = AW'(a);
    endtask

    task automatic model_reset();
        for (int b = 0; b < NS; b++) begin
            m_left[b] = 0;
            m_out[b]  = '0;
            m_vld[b]  = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [NS*DW-1:0] eo;
        logic [NS-1:0]    ev, eb;
        for (int b = 0; b < NS; b++) begin
            eo[b*DW+:DW] = m_out[b];
            ev[b]        = m_vld[b];
            eb[b]        = (m_left[b] != 0);
        end
        chk("Data_Out", 64'(bus.Data_Out), 64'(eo));
        chk("Data_Valid", 64'(bus.Data_Valid), 64'(ev));
        chk("Clear_Busy", 64'(bus.Clear_Busy), 64'(eb));
    endtask

    // One clock: model consumes the inputs present at the edge, then outputs
    // are compared 1 time unit later.
    task automatic step();
        logic          cs, we, re, clr;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd, rd;
        @(posedge clk);
        for (int b = 0; b < NS; b++) begin
            clr = bus.Mem_Clear[b];
            cs  = bus.En_Chip_Select[b];
            we  = bus.En_Write[b];
            re  = bus.En_Read[b];
            wa  = bus.Addr_Write[b*AW+:AW];
            ra  = bus.Addr_Read[b*AW+:AW];
            wd  = bus.Data_In[b*DW+:DW];
            if (m_left[b] > 0) begin
                m_mem[b][DEPTH - m_left[b]] = '0;
                m_left[b]--;
                m_vld[b] = 1'b0;
            end else if (clr) begin
                m_left[b] = DEPTH;
                m_vld[b]  = 1'b0;
            end else begin
                if (cs && re) begin
                    rd = m_mem[b][ra];
`ifdef SRAM_WRITE_FIRST_BYPASS_EN
                    if (we && wa == ra) rd = wd;
`endif
                    m_out[b] = rd;
                    m_vld[b] = 1'b1;
                end else begin
                    m_vld[b] = 1'b0;
                end
                if (cs && we) m_mem[b][wa] = wd;
            end
        end
        #1;
        compare_all();
    endtask

    initial begin
        logic [DW-1:0] coll_exp;
        idle_in();
        model_reset();
        for (int b = 0; b < NS; b++)
            for (int a = 0; a < DEPTH; a++) m_mem[b][a] = 'x;

        // Reset state
        #12;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Bring all banks to a known state
        bus.Mem_Clear = '1;
        step();
        idle_in();
        repeat (DEPTH) step();

        // Basic write then read, 1-cycle latency
        set_wr(0, 3, 16'hA5A5);
        step();
        idle_in();
        set_rd(0, 3);
        step();
        idle_in();
        chk("wr_rd_data", 64'(bus.Data_Out[15:0]), 64'h A5A5);
        chk("wr_rd_valid", 64'(bus.Data_Valid[0]), 64'd1);
        step();
        chk("wr_rd_valid_drop", 64'(bus.Data_Valid[0]), 64'd0);

        // Fill banks; bank2 all ones
        for (int a = 0; a < DEPTH; a++) begin
            set_wr(0, a, DW'($urandom));
            set_wr(1, a, DW'($urandom));
            set_wr(2, a, 16'hFFFF);
            step();
            idle_in();
        end

        // Clear bank2, with a read attempt mid-sweep
        bus.Mem_Clear[2] = 1'b1;
        step();
        idle_in();
        for (int i = 0; i < DEPTH; i++) begin
            chk("busy2_sweep", 64'(bus.Clear_Busy[2]), 64'd1);
            if (i == 5) set_rd(2, 4);
            step();
            idle_in();
            if (i == 5) chk("rd_during_clear", 64'(bus.Data_Valid[2]), 64'd0);
        end
        chk("busy2_done", 64'(bus.Clear_Busy[2]), 64'd0);
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(2, a);
            set_rd(0, a);
            set_rd(1, a);
            step();
            idle_in();
            chk("cleared_word", 64'(bus.Data_Out[2*DW+:DW]), 64'd0);
        end

        // Read/write collision on bank1 @5
        set_wr(1, 5, 16'h0001);
        step();
        idle_in();
        set_wr(1, 5, 16'h0002);
        set_rd(1, 5);
        step();
        idle_in();
`ifdef SRAM_WRITE_FIRST_BYPASS_EN
        coll_exp = 16'h0002;
`else
        coll_exp = 16'h0001;
`endif
        chk("collision", 64'(bus.Data_Out[DW+:DW]), 64'(coll_exp));
        set_rd(1, 5);
        step();
        idle_in();
        chk("after_collision", 64'(bus.Data_Out[DW+:DW]), 64'h0002);

        // Clear outranks a same-cycle write
        set_wr(1, 7, 16'h1234);
        step();
        idle_in();
        bus.Mem_Clear[1] = 1'b1;
        set_wr(1, 7, 16'hBEEF);
        set_rd(1, 7);
        step();
        idle_in();
        chk("clr_drop_valid", 64'(bus.Data_Valid[1]), 64'd0);
        repeat (DEPTH) step();
        set_rd(1, 7);
        step();
        idle_in();
        chk("clr_drop_word", 64'(bus.Data_Out[DW+:DW]), 64'd0);

        // Held clear retriggers after one idle cycle
        bus.Mem_Clear[1] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 17) chk("retrig_gap", 64'(bus.Clear_Busy[1]), 64'd0);
            if (i == 18) chk("retrig_start", 64'(bus.Clear_Busy[1]), 64'd1);
        end
        idle_in();
        begin
            int guard = 0;
            while (bus.Clear_Busy[1] && guard < 40) begin
                step();
                guard++;
            end
            chk("retrig_end_bound", 64'(bus.Clear_Busy[1]), 64'd0);
        end

        // Reset in the middle of a bank0 sweep
        for (int a = 0; a < DEPTH; a++) begin
            set_wr(0, a, DW'(16'h1000 + a));
            step();
            idle_in();
        end
        set_rd(0, 9);
        step();
        idle_in();
        bus.Mem_Clear[0] = 1'b1;
        step();
        idle_in();
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_dout0", 64'(bus.Data_Out[15:0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, a);
            step();
            idle_in();
            chk("partial_clear", 64'(bus.Data_Out[15:0]), (a < 8) ? 64'd0 : 64'(16'h1000 + a));
        end

        // No chip select: read ignored, output held
        bus.En_Read[0] = 1'b1;
        bus.Addr_Read[0+:AW] = 4'h2;
        step();
        idle_in();
        chk("nocs_valid", 64'(bus.Data_Valid[0]), 64'd0);
        chk("nocs_hold", 64'(bus.Data_Out[15:0]), 64'h100F);

        // Wrapped address 4'hE
        set_wr(0, 14, 16'hC0DE);
        step();
        idle_in();
        set_rd(0, 4'hE);
        step();
        idle_in();
        chk("wrap_addr", 64'(bus.Data_Out[15:0]), 64'hC0DE);

        // Random traffic
        repeat (400) begin
            for (int b = 0; b < NS; b++) begin
                bus.Mem_Clear[b]        = ($urandom_range(0, 39) == 0);
                bus.En_Chip_Select[b]   = ($urandom_range(0, 3) != 0);
                bus.En_Write[b]         = $urandom_range(0, 1);
                bus.En_Read[b]          = $urandom_range(0, 1);
                bus.Addr_Write[b*AW+:AW] = AW'($urandom);
                bus.Addr_Read[b*AW+:AW] = ($urandom_range(0, 3) == 0) ?
                                           bus.Addr_Write[b*AW+:AW] : AW'($urandom);
                bus.Data_In[b*DW+:DW]   = DW'($urandom);
            end
            step();
        end
        idle_in();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_bank_array.md
Name: sram_bank_array

Overview:
- Responder side of the memory-controller interface.
- Holds Nums_SRAM single-port-per-direction SRAM banks: two input-vector banks and one result bank for the dot-product engine.
- Consumes per-bank chip-select, read/write enables, packed read/write addresses and clear requests.
- Returns registered read data with a valid strobe, and sequences a per-bank zero-fill when clear is requested.

Parameters:
- Addr_Width, 4, address bits per bank.
- Ram_Depth, 1 << Addr_Width, words per bank.
- Nums_SRAM, 3, number of banks.
- Data_Width, 16, bits per word.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- Mem_reset_n  input  1  asynchronous active-low reset.
- Mem_Clear  input  Nums_SRAM  per-bank clear request, level-sampled.
- En_Chip_Select  input  Nums_SRAM  per-bank select; no access without it.
- En_Write  input  Nums_SRAM  per-bank write enable.
- En_Read  input  Nums_SRAM  per-bank read enable.
- Addr_Write  input  Nums_SRAM*Addr_Width  packed write addresses; bank i uses bits [i*Addr_Width +: Addr_Width].
- Addr_Read  input  Nums_SRAM*Addr_Width  packed read addresses; same packing.
- Data_In  input  Nums_SRAM*Data_Width  packed write data.
- Data_Out  output  Nums_SRAM*Data_Width  packed registered read data.
- Data_Valid  output  Nums_SRAM  per-bank one-cycle read-data strobe.
- Clear_Busy  output  Nums_SRAM  per-bank high while zero-fill runs.

Behaviour:
- Reset (Mem_reset_n low, asynchronous):
  - Data_Out=0, Data_Valid=0, Clear_Busy=0.
  - All bank FSMs go to IDLE; clear counters=0.
  - Array contents are NOT reset.
- Per-bank FSM states are IDLE and CLEARING.
- IDLE:
  - Write: if CS&&En_Write at the edge, mem[Addr_Write] <= Data_In slice.
  - Read: if CS&&En_Read, Data_Out slice <= mem[Addr_Read] and Data_Valid=1 on the next cycle. Latency is exactly 1 cycle.
  - Without a read, Data_Valid=0 and Data_Out holds its previous value.
  - Read and write in the same cycle are both performed.
  - Same-address read and write: read returns OLD data (read-first), unless the optional feature below is enabled.
  - Without CS, En_Read/En_Write are ignored.
- IDLE -> CLEARING when Mem_Clear[i]=1. Mem_Clear outranks any access in that cycle: the access is dropped and Data_Valid stays 0.
- CLEARING:
  - Writes zero to address clr_cnt each cycle, clr_cnt counting 0..Ram_Depth-1 (Ram_Depth cycles).
  - Clear_Busy=1 throughout; all external reads/writes to that bank are ignored; Data_Valid=0.
  - After address Ram_Depth-1 is written, returns to IDLE with Clear_Busy=0 the following cycle.
- Mem_Clear while already CLEARING is ignored; the sweep does not restart.
- Mem_Clear still high on return to IDLE starts a new sweep.
- Reset mid-clear aborts the sweep: contents are partially cleared, FSM goes to IDLE.
- Addresses use full-width wrap: the controller may present wrapped values (e.g. index-2 = 4'hE), which access that word normally.
- Banks are fully independent; no cross-bank arbitration.

Optional Feature:
- Macro SRAM_WRITE_FIRST_BYPASS_EN.
- Defined: a same-cycle same-address read and write returns the new Data_In value (bypass mux on the read path).
- Undefined: read-first; returns the stored old value. Array write timing is identical in both cases.

Decomposition:
- Shared package holds:
  - Default constants ADDR_WIDTH_DEF=4 and DATA_WIDTH_DEF=16.
  - Bank FSM state typedef (IDLE, CLEARING).
  - Slice-index helper function for packed buses.
- One sub-module, sram_bank (single bank: array, FSM, clear counter, read register, optional bypass), instantiated Nums_SRAM times by generate.
- The top level does only bus slicing.

Test Plan:
- Write/read: bank0 write 16'hA5A5 @ addr 3, then read addr 3 -> Data_Out[15:0]=16'hA5A5 and Data_Valid[0]=1 exactly one cycle after the read edge, 0 the cycle after.
- Clear:
  - Fill bank2 with 16'hFFFF, pulse Mem_Clear[2] one cycle -> Clear_Busy[2] high for 16 cycles.
  - A read during the sweep gives Data_Valid[2]=0.
  - Reads after the sweep return 0 at all 16 addresses.
  - Banks 0 and 1 are unchanged.
- Read/write collision: mem[5]=16'h0001; same cycle write 16'h0002 and read @5 -> Data_Out=16'h0001 (16'h0002 with SRAM_WRITE_FIRST_BYPASS_EN); a subsequent read gives 16'h0002.
- Clear priority and retrigger:
  - Mem_Clear[1] with CS/En_Write @ addr 7 in the same cycle -> write dropped, mem[7]=0 after the sweep.
  - Mem_Clear[1] held for 20 cycles -> the second sweep starts the cycle after the first ends.
- Reset mid-clear: assert Mem_reset_n=0 at sweep cycle 8 -> Clear_Busy, Data_Valid and Data_Out go 0 immediately (asynchronously). After release, addrs 0..7 read 0 and addrs 8..15 keep their old data.
- No-select/wrap: En_Read=1 with CS=0 -> Data_Valid=0 and Data_Out held; Addr_Read=4'hE with CS -> returns mem[14].
